// File: rtl/axil_wr_mux.sv
// axil_wr_mux: locks an rr_arbiter grant for one full AXI-Lite write (AW+W+B)
// and routes the granted master's channels to the single slave port.
module axil_wr_mux #(
  parameter int N      = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        s_awvalid,
  input  logic [N*ADDR_W-1:0] s_awaddr,
  input  logic [N*3-1:0]      s_awprot,
  output logic [N-1:0]        s_awready,
  input  logic [N-1:0]        s_wvalid,
  input  logic [N*DATA_W-1:0] s_wdata,
  input  logic [N*STRB_W-1:0] s_wstrb,
  output logic [N-1:0]        s_wready,
  output logic [N-1:0]        s_bvalid,
  output logic [1:0]          s_bresp,
  input  logic [N-1:0]        s_bready,
  output logic                m_awvalid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  input  logic                m_awready,
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [STRB_W-1:0]   m_wstrb,
  input  logic                m_wready,
  input  logic                m_bvalid,
  input  logic [1:0]          m_bresp,
  output logic                m_bready,
  output logic [N-1:0]        arb_req,
  input  logic [N-1:0]        arb_grant,
  output logic                arb_done
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, gnt_idx;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic             sel_awvalid, sel_wvalid, sel_bready, xfer, aw_hs, w_hs;
  assign xfer = state_q == XFER;
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) gnt_idx = arb_grant[i] ? SEL_W'(i) : gnt_idx;
  end
  // Data buses stay zero outside XFER so idle slaves never see stale payloads.
  always_comb begin
    sel_awvalid = 1'b0;
    sel_wvalid  = 1'b0;
    sel_bready  = 1'b0;
    m_awaddr    = '0;
    m_awprot    = '0;
    m_wdata     = '0;
    m_wstrb     = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_awvalid = s_awvalid[i];
        sel_wvalid  = s_wvalid[i];
        sel_bready  = s_bready[i];
        m_awaddr    = xfer ? s_awaddr[i*ADDR_W +: ADDR_W] : '0;
        m_awprot    = xfer ? s_awprot[i*3 +: 3] : '0;
        m_wdata     = xfer ? s_wdata[i*DATA_W +: DATA_W] : '0;
        m_wstrb     = xfer ? s_wstrb[i*STRB_W +: STRB_W] : '0;
      end
    end
  end
  assign aw_hs = xfer && sel_awvalid && !aw_done_q && m_awready;
  assign w_hs  = xfer && sel_wvalid && !w_done_q && m_wready;
  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    arb_req          = (state_q == IDLE) ? s_awvalid : (N'(1) << sel_q);
    m_awvalid        = xfer && sel_awvalid && !aw_done_q;
    m_wvalid         = xfer && sel_wvalid && !w_done_q;
    s_awready        = '0;
    s_wready         = '0;
    s_bvalid         = '0;
    s_awready[sel_q] = xfer && m_awready && !aw_done_q;
    s_wready[sel_q]  = xfer && m_wready && !w_done_q;
    s_bvalid[sel_q]  = (state_q == RESP) && m_bvalid;
    s_bresp          = (state_q == RESP) ? m_bresp : 2'b00;
    m_bready         = (state_q == RESP) && sel_bready;
    arb_done         = m_bready && m_bvalid;
    if (state_q == IDLE && arb_grant != '0) begin
      sel_d   = gnt_idx;
      state_d = XFER;
    end
    if (xfer) begin
      aw_done_d = aw_done_q || aw_hs;
      w_done_d  = w_done_q || w_hs;
      state_d   = (aw_done_d && w_done_d) ? RESP : XFER;
      aw_done_d = aw_done_d && !(aw_done_d && w_done_d);
      w_done_d  = w_done_d && (state_d == XFER);
    end
    if (state_q == RESP && arb_done) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule
